// File: rtl/block_ram_fifo_ctrl.sv
// FIFO controller that wraps one external single-port, 1-cycle-latency block RAM.
// A one-entry output register hides the RAM read latency and holds deqData under back-pressure.
module block_ram_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned INDEX_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enqValid,
    output logic                   enqReady,
    input  logic [DATA_WIDTH-1:0]  enqData,
    output logic                   deqValid,
    input  logic                   deqReady,
    output logic [DATA_WIDTH-1:0]  deqData,
    output logic [INDEX_WIDTH-1:0] ramIndex,
    output logic [DATA_WIDTH-1:0]  ramWriteValue,
    output logic                   ramWriteEnable,
    input  logic [DATA_WIDTH-1:0]  ramReadValue,
    output logic [INDEX_WIDTH:0]   count
);

    localparam int unsigned EntryCount = 1 << INDEX_WIDTH;
    localparam logic [INDEX_WIDTH:0]   FullCount = (INDEX_WIDTH + 1)'(EntryCount);
    localparam logic [INDEX_WIDTH-1:0] PtrInc    = INDEX_WIDTH'(1);
    localparam logic [INDEX_WIDTH:0]   CountInc  = (INDEX_WIDTH + 1)'(1);

    logic [INDEX_WIDTH-1:0] head_ptr_q, head_ptr_d;
    logic [INDEX_WIDTH-1:0] tail_ptr_q, tail_ptr_d;
    logic [INDEX_WIDTH:0]   ram_count_q, ram_count_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic                   read_in_flight_q, read_in_flight_d;

    logic enq_fire;
    logic deq_fire;
    logic slot_free;
    logic bypass;
    logic ram_write;
    logic ram_read;

    always_comb begin
        enqReady  = !rst && (ram_count_q < FullCount);
        deqValid  = out_valid_q;
        deqData   = out_data_q;
        enq_fire  = enqValid && enqReady;
        deq_fire  = out_valid_q && deqReady;
        slot_free = !read_in_flight_q && (!out_valid_q || deq_fire);
        // Bypass only when nothing older sits in the RAM or is on its way out of it.
        bypass    = enq_fire && (ram_count_q == '0) && slot_free;
        ram_write = enq_fire && !bypass;
        ram_read  = !ram_write && (ram_count_q != '0) && slot_free;

        ramWriteEnable = ram_write;
        ramWriteValue  = enqData;
        ramIndex       = ram_write ? tail_ptr_q : head_ptr_q;

        count = ram_count_q
              + {{INDEX_WIDTH{1'b0}}, out_valid_q}
              + {{INDEX_WIDTH{1'b0}}, read_in_flight_q};
    end

    always_comb begin
        head_ptr_d       = head_ptr_q;
        tail_ptr_d       = tail_ptr_q;
        ram_count_d      = ram_count_q;
        out_valid_d      = out_valid_q;
        out_data_d       = out_data_q;
        read_in_flight_d = ram_read;

        if (ram_write) begin
            tail_ptr_d  = tail_ptr_q + PtrInc;
            ram_count_d = ram_count_q + CountInc;
        end else if (ram_read) begin
            head_ptr_d  = head_ptr_q + PtrInc;
            ram_count_d = ram_count_q - CountInc;
        end

        if (read_in_flight_q) begin
            out_valid_d = 1'b1;
            out_data_d  = ramReadValue;
        end else if (bypass) begin
            out_valid_d = 1'b1;
            out_data_d  = enqData;
        end else if (deq_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr_q       <= '0;
            tail_ptr_q       <= '0;
            ram_count_q      <= '0;
            out_valid_q      <= 1'b0;
            out_data_q       <= '0;
            read_in_flight_q <= 1'b0;
        end else begin
            head_ptr_q       <= head_ptr_d;
            tail_ptr_q       <= tail_ptr_d;
            ram_count_q      <= ram_count_d;
            out_valid_q      <= out_valid_d;
            out_data_q       <= out_data_d;
            read_in_flight_q <= read_in_flight_d;
        end
    end

endmodule

// File: tb/tb_block_ram_fifo_ctrl.sv
// Bench for block_ram_fifo_ctrl with a 4-entry RAM: cycle-exact vector table,
// then a randomized stream against a queue model, then reset with entries held.
module tb_block_ram_fifo_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned IW = 2;

    localparam logic [5:0] MEr  = 6'h01;
    localparam logic [5:0] MDv  = 6'h02;
    localparam logic [5:0] MCnt = 6'h08;
    localparam logic [5:0] MWe  = 6'h10;
    localparam logic [5:0] MIdx = 6'h20;
    localparam logic [5:0] MStd = MEr | MDv | MCnt | MWe;

    logic          clk = 1'b0;
    logic          rst;
    logic          enqValid;
    logic          enqReady;
    logic [DW-1:0] enqData;
    logic          deqValid;
    logic          deqReady;
    logic [DW-1:0] deqData;
    logic [IW-1:0] ramIndex;
    logic [DW-1:0] ramWriteValue;
    logic          ramWriteEnable;
    logic [DW-1:0] ramReadValue;
    logic [IW:0]   count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    block_ram_fifo_ctrl #(
        .DATA_WIDTH  (DW),
        .INDEX_WIDTH (IW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enqValid       (enqValid),
        .enqReady       (enqReady),
        .enqData        (enqData),
        .deqValid       (deqValid),
        .deqReady       (deqReady),
        .deqData        (deqData),
        .ramIndex       (ramIndex),
        .ramWriteValue  (ramWriteValue),
        .ramWriteEnable (ramWriteEnable),
        .ramReadValue   (ramReadValue),
        .count          (count)
    );

    // Single-port RAM with registered read data.
    logic [DW-1:0] mem [4];
    always @(posedge clk) begin
        if (ramWriteEnable) mem[ramIndex] <= ramWriteValue;
        ramReadValue <= mem[ramIndex];
    end

    typedef struct {
        logic          rst;
        logic          ev;
        logic [DW-1:0] ed;
        logic          dr;
        logic [5:0]    m;
        logic          er;
        logic          dv;
        logic [DW-1:0] dd;
        logic [2:0]    cnt;
        logic          we;
        logic [1:0]    idx;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic r, input logic ev, input logic [DW-1:0] ed,
                               input logic dr, input logic [5:0] m, input logic er,
                               input logic dv, input logic [DW-1:0] dd, input logic [2:0] cnt,
                               input logic we, input logic [1:0] idx);
        vec_t t;
        t.rst = r; t.ev = ev; t.ed = ed; t.dr = dr; t.m = m; t.er = er;
        t.dv = dv; t.dd = dd; t.cnt = cnt; t.we = we; t.idx = idx;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ev, input logic [DW-1:0] ed, input logic dr);
        @(negedge clk);
        rst = r; enqValid = ev; enqData = ed; deqReady = dr;
        #1;
    endtask

    logic [DW-1:0] sb[$];
    int            sent;
    int            rcvd;
    int            cyc;
    logic          prev_hold;
    logic [DW-1:0] prev_dd;
    logic [DW-1:0] exp_d;

    initial begin
        rst = 1'b1; enqValid = 1'b0; enqData = '0; deqReady = 1'b0;

        // Reset, bypass, fill, drain.
        vecs.push_back(v(1, 1, 32'h11, 0, MEr | MWe, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 1, 32'h11, 0, MStd, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, MStd, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 32'hA5, 0, MStd, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, MStd, 1, 1, 32'hA5, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, MStd, 1, 1, 32'hA5, 1, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, MStd, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 2, 0, MStd | MIdx, 1, 1, 1, 1, 1, 0));
        vecs.push_back(v(0, 1, 3, 0, MStd | MIdx, 1, 1, 1, 2, 1, 1));
        vecs.push_back(v(0, 1, 4, 0, MStd | MIdx, 1, 1, 1, 3, 1, 2));
        vecs.push_back(v(0, 1, 5, 0, MStd | MIdx, 1, 1, 1, 4, 1, 3));
        vecs.push_back(v(0, 1, 6, 0, MStd, 0, 1, 1, 5, 0, 0));
        vecs.push_back(v(0, 1, 6, 0, MStd, 0, 1, 1, 5, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, MStd | MIdx, 0, 1, 1, 5, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, MStd, 1, 0, 0, 4, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, MStd | MIdx, 1, 1, 2, 4, 0, 1));
        vecs.push_back(v(0, 0, 0, 1, MStd, 1, 0, 0, 3, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, MStd | MIdx, 1, 1, 3, 3, 0, 2));
        vecs.push_back(v(0, 0, 0, 1, MStd, 1, 0, 0, 2, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, MStd | MIdx, 1, 1, 4, 2, 0, 3));
        vecs.push_back(v(0, 0, 0, 1, MStd, 1, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, MStd, 1, 1, 5, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, MStd, 1, 0, 0, 0, 0, 0));
        // Writes hold off reads while the output slot is free.
        vecs.push_back(v(0, 1, 32'h10, 0, MStd, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 32'h11, 0, MStd | MIdx, 1, 1, 32'h10, 1, 1, 0));
        vecs.push_back(v(0, 1, 32'h12, 1, MStd | MIdx, 1, 1, 32'h10, 2, 1, 1));
        vecs.push_back(v(0, 1, 32'h13, 1, MStd | MIdx, 1, 0, 0, 2, 1, 2));
        vecs.push_back(v(0, 1, 32'h14, 1, MStd | MIdx, 1, 0, 0, 3, 1, 3));
        vecs.push_back(v(0, 0, 0, 1, MStd | MIdx, 0, 0, 0, 4, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, MStd, 1, 0, 0, 4, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, MStd | MIdx, 1, 1, 32'h11, 4, 0, 1));
        vecs.push_back(v(0, 0, 0, 1, MStd, 1, 0, 0, 3, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, MStd | MIdx, 1, 1, 32'h12, 3, 0, 2));
        vecs.push_back(v(0, 0, 0, 1, MStd, 1, 0, 0, 2, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, MStd | MIdx, 1, 1, 32'h13, 2, 0, 3));
        vecs.push_back(v(0, 0, 0, 1, MStd, 1, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, MStd, 1, 1, 32'h14, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, MStd, 1, 0, 0, 0, 0, 0));
        // Same-cycle enq and deq on a single-entry FIFO refills through the bypass.
        vecs.push_back(v(0, 1, 32'h20, 0, MStd, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 32'h21, 1, MStd, 1, 1, 32'h20, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, MStd, 1, 1, 32'h21, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, MStd, 1, 1, 32'h21, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, MStd, 1, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].ev, vecs[i].ed, vecs[i].dr);
            if ((vecs[i].m & MEr) != 0)
                chk($sformatf("v%0d_enqReady", i), 32'(enqReady), 32'(vecs[i].er));
            if ((vecs[i].m & MDv) != 0) begin
                chk($sformatf("v%0d_deqValid", i), 32'(deqValid), 32'(vecs[i].dv));
                if (vecs[i].dv)
                    chk($sformatf("v%0d_deqData", i), deqData, vecs[i].dd);
            end
            if ((vecs[i].m & MCnt) != 0)
                chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            if ((vecs[i].m & MWe) != 0)
                chk($sformatf("v%0d_ramWriteEnable", i), 32'(ramWriteEnable), 32'(vecs[i].we));
            if ((vecs[i].m & MIdx) != 0)
                chk($sformatf("v%0d_ramIndex", i), 32'(ramIndex), 32'(vecs[i].idx));
        end

        // Randomized stream against an ordered queue model.
        sent = 0; rcvd = 0; cyc = 0; prev_hold = 1'b0; prev_dd = '0;
        while (rcvd < 40 && cyc < 3000) begin
            drive(0, (sent < 40) && ($urandom_range(0, 3) != 0), 32'h100 + 32'(sent),
                  $urandom_range(0, 2) != 0);
            if (prev_hold) begin
                chk("rand_hold_valid", 32'(deqValid), 32'd1);
                chk("rand_hold_data", deqData, prev_dd);
            end
            chk("rand_count", 32'(count), 32'(sb.size()));
            if (sb.size() < 4)      chk("rand_enqReady_open", 32'(enqReady), 32'd1);
            else if (sb.size() == 5) chk("rand_enqReady_full", 32'(enqReady), 32'd0);
            if (deqValid && deqReady) begin
                if (sb.size() == 0) begin
                    exp_d = 'x;
                    chk("rand_deq_on_empty", 32'(deqValid), 32'd0);
                end else begin
                    exp_d = sb.pop_front();
                    chk("rand_data", deqData, exp_d);
                end
                rcvd++;
            end
            if (enqValid && enqReady) begin
                sb.push_back(enqData);
                sent++;
            end
            prev_hold = deqValid && !deqReady;
            prev_dd   = deqData;
            cyc++;
        end
        chk("rand_all_received", 32'(rcvd), 32'd40);

        // Reset while holding three entries, then a fresh bypass.
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        drive(0, 1, 32'h30, 0);
        drive(0, 1, 32'h31, 0);
        drive(0, 1, 32'h32, 0);
        drive(0, 0, 0, 0);
        chk("rst_pre_count", 32'(count), 32'd3);
        drive(1, 1, 32'h33, 1);
        chk("rst_enqReady", 32'(enqReady), 32'd0);
        chk("rst_we", 32'(ramWriteEnable), 32'd0);
        drive(0, 0, 0, 0);
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_deqValid", 32'(deqValid), 32'd0);
        chk("post_rst_enqReady", 32'(enqReady), 32'd1);
        drive(0, 1, 32'h7, 0);
        chk("post_rst_bypass_we", 32'(ramWriteEnable), 32'd0);
        drive(0, 0, 0, 0);
        chk("post_rst_bypass_valid", 32'(deqValid), 32'd1);
        chk("post_rst_bypass_data", deqData, 32'h7);
        chk("post_rst_bypass_count", 32'(count), 32'd1);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        chk("post_rst_drained", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/block_ram_fifo_ctrl.md
Name: block_ram_fifo_ctrl

Overview:
Controller that turns one external 1-RW, 1-cycle-latency BlockRam instance into an in-order FIFO with valid/ready handshakes on both sides. It drives the RAM's index, writeValue and writeEnable inputs and consumes its readValue output. A one-entry output register keeps deqData stable under back-pressure and hides the RAM read latency. Used as the buffering stage between pipeline producers and consumers, for example miss queues and store buffers.

Parameters:
DATA_WIDTH, 32, payload width; must equal the attached RAM's DATA_WIDTH.
INDEX_WIDTH, 4, RAM index width; RAM depth is EntryCount = 1 << INDEX_WIDTH.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
enqValid  input  1  producer has data.
enqReady  output  1  controller can accept data.
enqData  input  DATA_WIDTH  payload to enqueue.
deqValid  output  1  deqData is valid.
deqReady  input  1  consumer accepts deqData.
deqData  output  DATA_WIDTH  head-of-queue payload (output register).
ramIndex  output  INDEX_WIDTH  to RAM index.
ramWriteValue  output  DATA_WIDTH  to RAM writeValue.
ramWriteEnable  output  1  to RAM writeEnable.
ramReadValue  input  DATA_WIDTH  from RAM readValue; valid 1 cycle after the read index is driven.
count  output  INDEX_WIDTH+1  total entries held: ramCount + outValid + readInFlight.

Behaviour:
- State:
  - headPtr, tailPtr: INDEX_WIDTH bits each, wrap modulo EntryCount.
  - ramCount: 0..EntryCount.
  - outValid, outData: the output register.
  - readInFlight: 1 bit.
- Reset: all state cleared to 0. The cycle after rst is released: deqValid=0, count=0, enqReady=1.
- While rst=1: enqReady=0, ramWriteEnable=0, and deqValid follows the cleared state. RAM contents are not cleared; they are dead because the pointers reset.
- Reset mid-operation discards every entry, including one in flight. ramReadValue arriving after reset is ignored.
- Handshake signals:
  - enqFire = enqValid & enqReady.
  - deqFire = deqValid & deqReady.
  - enqReady = !rst & (ramCount < EntryCount), computed from registers only.
  - deqValid = outValid; deqData = outData.
  - deqData is held stable while deqValid & !deqReady.
- slotFree = !readInFlight & (!outValid | deqFire).
- Bypass (empty path):
  - Condition: enqFire & ramCount==0 & slotFree.
  - Action: enqData goes straight into outData and outValid=1 next cycle.
  - No RAM write. Latency is 1 cycle.
- RAM write (priority user of the single port):
  - Condition: enqFire & !bypass.
  - Outputs: ramWriteEnable=1, ramIndex=tailPtr, ramWriteValue=enqData.
  - Update: tailPtr+1, ramCount+1.
- RAM read:
  - Condition: !ramWriteEnable & ramCount>0 & slotFree.
  - Outputs: ramIndex=headPtr.
  - Update: headPtr+1, ramCount-1, readInFlight=1 next cycle.
  - If a write occurs in the same cycle, the read is deferred.
- Read return: when readInFlight=1, the next state is outData=ramReadValue, outValid=1 and readInFlight=0.
- Otherwise, if deqFire, outValid=0.
- Idle port: ramIndex=headPtr, ramWriteEnable=0, ramWriteValue=enqData.
- Same-cycle read and write to the RAM never occur.
- Invariants:
  - readInFlight and outValid are never both 1.
  - count ≤ EntryCount+1.
- Throughput:
  - Enqueue: 1 per cycle until full.
  - Drain from RAM: 1 per 2 cycles (read, then capture). Drain is stalled by any enqueue that writes to the RAM.
- Order: strict FIFO. Bypass is only permitted when the RAM holds nothing and nothing is in flight.
- Full: when ramCount==EntryCount, enqReady=0. An enqValid held high is not accepted, and state is unchanged apart from dequeue progress.
- Simultaneous enq and deq with outValid=1 and ramCount==0: bypass refills outData in the same cycle, so deqValid stays 1 and count is unchanged.

Test Plan:
1. Reset: hold rst 2 cycles with enqValid=1 -> ramWriteEnable=0, enqReady=0 during rst; after release deqValid=0, count=0, enqReady=1.
2. Bypass: empty FIFO, enq 0xA5 at cycle t -> ramWriteEnable=0 at t; at t+1 deqValid=1, deqData=0xA5, count=1.
3. Fill (INDEX_WIDTH=2): deqReady=0, enq 1..6 back-to-back -> item 1 goes to the output register; items 2..5 are written at RAM indices 0..3; enqReady=0 after the 5th accept; count=5; item 6 is not taken.
4. Drain: from the state in test 3, set deqReady=1 -> deqData sequence 1,2,3,4,5; after the first item deqValid pulses every 2nd cycle; count reaches 0.
5. Port conflict: ramCount=2, slot free, enqValid=1 for 3 cycles -> no RAM reads in those cycles, 3 RAM writes; then reads resume and dequeue order is preserved exactly.
6. Wrap and reset: stream 40 items with random enq/deq stalls and check order against a scoreboard; then assert rst with count=3 -> next cycle count=0, deqValid=0, and a subsequent enq 0x7 bypasses correctly.
